// File: rtl/mem_arb.sv
// mem_arb: shares the byte-wide memory array between instruction fetch (IF)
// and load/store (LS). Each request becomes 1, 2 or 4 byte accesses. The most
// significant byte goes to the lowest address. Read bytes are gathered into a
// 32-bit word, which is returned with a one-cycle done pulse.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (word reads only)
//   if_done/if_rdata         fetch completion pulse and fetched word
//   ls_req/ls_we/ls_size     load/store request, direction, size (00 b, 01 h, 1x w)
//   ls_addr/ls_wdata         load/store byte address and right-justified store data
//   ls_done/ls_rdata         load/store completion pulse and zero-extended load data
//   mem_addr/mem_we/mem_wdata  byte port to the array
//   mem_rdata                array read byte, valid one cycle after mem_addr
//   busy                     high whenever a transfer is in progress
module mem_arb #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [1:0]    ls_size,
    input  logic [31:0]   ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic          ls_done,
    output logic [31:0]   ls_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, XFER, LAST, RESP} state_t;

    state_t        state_reg, state_next;
    logic          port_reg;      // granted port: 1 = LS, 0 = IF
    logic          last_reg;      // port served most recently: 1 = LS
    logic [AW-1:0] addr_reg;
    logic          we_reg;
    logic [31:0]   wdata_reg;
    logic [2:0]    n_reg;         // number of byte accesses
    logic [2:0]    cnt_reg;       // byte index within the transfer
    logic [31:0]   asm_reg;       // read data assembly register
    logic          if_done_reg, ls_done_reg;
    logic [31:0]   if_rdata_reg, ls_rdata_reg;

    logic          grant_ls;
    logic [2:0]    req_n;
    logic          load_shift;
    logic [31:0]   asm_shifted;
    logic [1:0]    lane_sel;
    logic [7:0]    wdata_lane [4];
    logic          unused_addr_bits;

    // Only the low AW address bits reach the array.
    assign unused_addr_bits = ^{if_addr[31:AW], ls_addr[31:AW]};

    // On a tie, LS wins unless it was the port served last.
    assign grant_ls = ls_req && !(if_req && last_reg);

    // The first XFER cycle only presents an address; its data arrives a cycle
    // later, so loads shift from the second XFER cycle through LAST.
    assign load_shift  = !we_reg && (((state_reg == XFER) && (cnt_reg != 3'd0))
                                     || (state_reg == LAST));
    assign asm_shifted = {asm_reg[23:0], mem_rdata};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_lane[gi] = wdata_reg[8*gi +: 8];
        end
    endgenerate

    // Big-endian: access k carries byte (n-1-k) of the store data.
    assign lane_sel = 2'(n_reg - 3'd1 - cnt_reg);

    assign mem_we    = (state_reg == XFER) && we_reg;
    assign mem_addr  = (state_reg == XFER) ? addr_reg + AW'(cnt_reg) : '0;
    assign mem_wdata = mem_we ? wdata_lane[lane_sel] : 8'h00;
    assign busy      = (state_reg != IDLE);
    assign if_done   = if_done_reg;
    assign ls_done   = ls_done_reg;
    assign if_rdata  = if_rdata_reg;
    assign ls_rdata  = ls_rdata_reg;

    always_comb begin
        req_n = 3'd4;
        case (ls_size)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            default: req_n = 3'd4;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (if_req || ls_req) state_next = XFER;
            XFER:    if (cnt_reg == n_reg - 3'd1) state_next = LAST;
            LAST:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            port_reg     <= 1'b0;
            last_reg     <= 1'b0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            n_reg        <= 3'd0;
            cnt_reg      <= 3'd0;
            asm_reg      <= '0;
            if_done_reg  <= 1'b0;
            ls_done_reg  <= 1'b0;
            if_rdata_reg <= '0;
            ls_rdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            if_done_reg <= 1'b0;
            ls_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (if_req || ls_req) begin
                        port_reg  <= grant_ls;
                        addr_reg  <= grant_ls ? ls_addr[AW-1:0] : if_addr[AW-1:0];
                        we_reg    <= grant_ls && ls_we;
                        wdata_reg <= grant_ls ? ls_wdata : 32'h0;
                        n_reg     <= grant_ls ? req_n : 3'd4;
                        cnt_reg   <= 3'd0;
                        asm_reg   <= '0;
                    end
                end
                XFER: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (load_shift) asm_reg <= asm_shifted;
                end
                LAST: begin
                    // The final byte is folded in here so the result is
                    // already registered during the done cycle.
                    if (load_shift) asm_reg <= asm_shifted;
                    if (port_reg) begin
                        ls_done_reg  <= 1'b1;
                        ls_rdata_reg <= load_shift ? asm_shifted : asm_reg;
                    end else begin
                        if_done_reg  <= 1'b1;
                        if_rdata_reg <= load_shift ? asm_shifted : asm_reg;
                    end
                end
                RESP: begin
                    last_reg <= port_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed testbench for mem_arb with a transaction-level reference model.
module tb_mem_arb;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_done;
    logic [31:0]   if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [1:0]    ls_size = 2'b00;
    logic [31:0]   ls_addr = '0;
    logic [31:0]   ls_wdata = '0;
    logic          ls_done;
    logic [31:0]   ls_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;

    // Memory-array preload port, used only while the arbiter is idle.
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arb #(.AW(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Synchronous byte memory array.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // On each grant the model expands the request into one expected entry
    // per cycle (n byte accesses, one quiet cycle, one response cycle).
    typedef struct packed {
        logic        xfer;
        logic        we;
        logic [9:0]  addr;
        logic [7:0]  wdata;
        logic        done_if;
        logic        done_ls;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur, ent;
    logic [7:0]  ref_mem [0:1023];
    logic        have;
    logic        m_last_ls = 1'b0;
    logic        g_ls, w;
    logic [9:0]  a, ak;
    int          n;
    logic [31:0] v, wd;
    logic [31:0] exp_if_rd = '0, exp_ls_rd = '0;

    always @(negedge clk) begin
        if (pre_we) ref_mem[pre_addr] = pre_data;
        have = (exp_q.size() > 0);
        if (have) cur = exp_q.pop_front();
        else cur = '0;
        // The array write happens on the next edge even if reset is high.
        if (have && cur.we) ref_mem[cur.addr] = cur.wdata;
        if (rst) begin
            exp_q.delete();
            m_last_ls = 1'b0;
            exp_if_rd = '0;
            exp_ls_rd = '0;
        end else begin
            if (cur.done_if) exp_if_rd = cur.rdata;
            if (cur.done_ls) exp_ls_rd = cur.rdata;
            chk("busy", busy, have);
            chk("mem_we", mem_we, cur.we);
            if (cur.xfer) chk("mem_addr", mem_addr, cur.addr);
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            chk("if_done", if_done, cur.done_if);
            chk("ls_done", ls_done, cur.done_ls);
            chk("if_rdata", if_rdata, exp_if_rd);
            chk("ls_rdata", ls_rdata, exp_ls_rd);
            if (!have && (if_req || ls_req)) begin
                g_ls = ls_req && !(if_req && m_last_ls);
                m_last_ls = g_ls;
                w  = g_ls && ls_we;
                a  = g_ls ? ls_addr[9:0] : if_addr[9:0];
                wd = ls_wdata;
                n  = !g_ls ? 4 : (ls_size == 2'b00 ? 1 : (ls_size == 2'b01 ? 2 : 4));
                v = 0;
                for (int k = 0; k < n; k++) begin
                    ak = a + 10'(k);
                    v = (v << 8) | 32'(ref_mem[ak]);
                end
                for (int k = 0; k < n; k++) begin
                    ent = '0;
                    ent.xfer = 1'b1;
                    ent.we = w;
                    ent.addr = a + 10'(k);
                    ent.wdata = w ? 8'(wd >> (8 * (n - 1 - k))) : 8'h00;
                    exp_q.push_back(ent);
                end
                ent = '0;
                exp_q.push_back(ent);
                ent.done_if = !g_ls;
                ent.done_ls = g_ls;
                ent.rdata = w ? 32'h0 : v;
                exp_q.push_back(ent);
            end
        end
    end

    // Order in which the DUT issued done pulses (1 = LS, 0 = IF).
    bit done_log[$];
    always @(negedge clk) begin
        if (!rst && if_done) done_log.push_back(1'b0);
        if (!rst && ls_done) done_log.push_back(1'b1);
    end

    // ---------------- stimulus ----------------
    task automatic preload(input logic [9:0] ad, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = ad; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] ad, output int lat);
        if_req = 1'b1; if_addr = ad;
        lat = 0;
        forever begin
            @(negedge clk);
            if (if_done) break;
            lat++;
            if (lat > 60) begin
                chk("if_timeout", 32'(lat), 32'd0);
                break;
            end
        end
        $display("txn IF addr=%h rdata=%h lat=%0d", ad, if_rdata, lat);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic ls_txn(input logic we, input logic [1:0] sz, input logic [31:0] ad,
                          input logic [31:0] wdv, output int lat);
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = ad; ls_wdata = wdv;
        lat = 0;
        forever begin
            @(negedge clk);
            if (ls_done) break;
            lat++;
            if (lat > 60) begin
                chk("ls_timeout", 32'(lat), 32'd0);
                break;
            end
        end
        $display("txn LS we=%0d size=%0d addr=%h wdata=%h rdata=%h lat=%0d",
                 we, sz, ad, wdv, ls_rdata, lat);
        @(posedge clk); #1;
        ls_req = 1'b0;
    endtask

    int lat_if, lat_ls, ndone, guard;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_if_rdata", if_rdata, 32'h0);
        chk("reset_mem_we", mem_we, 1'b0);
        @(posedge clk); #1;

        preload(10'h000, 8'hDE); preload(10'h001, 8'hAD);
        preload(10'h002, 8'hBE); preload(10'h003, 8'hEF);
        preload(10'h00A, 8'h00); preload(10'h00B, 8'h00);
        preload(10'h00C, 8'h5A);
        preload(10'h3FE, 8'h11); preload(10'h3FF, 8'h22);
        for (int i = 20; i < 24; i++) preload(10'(i), 8'h00);

        // Word fetch.
        if_txn(32'h0, lat_if);
        chk("if_word_lat", 32'(lat_if), 32'd6);
        chk("if_word_data", if_rdata, 32'hDEADBEEF);

        preload(10'h003, 8'hF0);

        // Half store.
        ls_txn(1'b1, 2'b01, 32'd10, 32'h00001234, lat_ls);
        chk("st_half_lat", 32'(lat_ls), 32'd4);
        @(posedge clk); #1;
        chk("st_half_m10", 32'(mem[10]), 32'h12);
        chk("st_half_m11", 32'(mem[11]), 32'h34);
        chk("st_half_m12", 32'(mem[12]), 32'h5A);

        // Byte load, zero-extended.
        ls_txn(1'b0, 2'b00, 32'd3, 32'h0, lat_ls);
        chk("ld_byte_lat", 32'(lat_ls), 32'd3);
        chk("ld_byte_data", ls_rdata, 32'h000000F0);

        // Reset, then simultaneous IF and wrapping LS word load.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        done_log.delete();
        fork
            if_txn(32'h0, lat_if);
            ls_txn(1'b0, 2'b10, 32'h3FE, 32'h0, lat_ls);
        join
        chk("tie_count", 32'(done_log.size()), 32'd2);
        if (done_log.size() == 2) begin
            chk("tie_first_ls", 32'(done_log[0]), 32'd1);
            chk("tie_second_if", 32'(done_log[1]), 32'd0);
        end
        chk("tie_ls_lat", 32'(lat_ls), 32'd6);
        chk("wrap_data", ls_rdata, 32'h1122DEAD);
        chk("tie_if_data", if_rdata, 32'hDEADBEF0);

        // LS served last, then both held: grants go IF, LS, IF.
        ls_txn(1'b0, 2'b00, 32'd10, 32'h0, lat_ls);
        chk("ld_byte10", ls_rdata, 32'h00000012);
        done_log.delete();
        if_req = 1'b1; if_addr = 32'h0;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'd10;
        ndone = 0;
        guard = 0;
        while (ndone < 3 && guard < 100) begin
            @(negedge clk);
            if (if_done || ls_done) ndone++;
            guard++;
        end
        chk("held_done_count", 32'(ndone), 32'd3);
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;
        $display("txn held IF/LS dones=%0d", ndone);
        if (done_log.size() == 3) begin
            chk("held_g0_if", 32'(done_log[0]), 32'd0);
            chk("held_g1_ls", 32'(done_log[1]), 32'd1);
            chk("held_g2_if", 32'(done_log[2]), 32'd0);
        end else begin
            chk("held_log_size", 32'(done_log.size()), 32'd3);
        end
        chk("held_ls_data", ls_rdata, 32'h00001234);
        repeat (2) @(posedge clk); #1;

        // Word store abandoned by reset after two bytes.
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'd20;
        ls_wdata = 32'hA1B2C3D4;
        guard = 0;
        forever begin
            @(negedge clk);
            if (mem_we && mem_addr == 10'd20) break;
            guard++;
            if (guard > 40) begin
                chk("abort_start_timeout", 32'(guard), 32'd0);
                break;
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; ls_req = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_mem_we", mem_we, 1'b0);
        done_log.delete();
        repeat (8) @(posedge clk);
        #1;
        $display("txn LS store aborted addr=14 mem=%h %h %h %h",
                 mem[20], mem[21], mem[22], mem[23]);
        chk("abort_no_done", 32'(done_log.size()), 32'd0);
        chk("abort_m20", 32'(mem[20]), 32'hA1);
        chk("abort_m21", 32'(mem[21]), 32'hB2);
        chk("abort_m22", 32'(mem[22]), 32'h00);
        chk("abort_m23", 32'(mem[23]), 32'h00);
        chk("abort_ls_rdata", ls_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0t exp=finish", $time);
        $fatal(1, "timeout");
    end

endmodule
